// File: rtl/addsub_serial.sv
// Bit-serial adder/subtractor: one full-adder cell, one bit per clock, LSB first.
// Subtraction is a + ~b + 1, so the operand b is inverted at accept time and carry seeded with m.
module addsub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_m;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum;
    logic             w_carry;
    logic             w_last;

    assign w_sum   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_carry = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_s      <= '0;
            r_cnt    <= '0;
            r_m      <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b ^ {WIDTH{m}};
                        r_m     <= m;
                        r_carry <= m;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= {w_sum, r_sum_sh[WIDTH-1:1]};
                    r_carry  <= w_carry;
                    r_cnt    <= r_cnt + CW'(1);
                    // Results are published only on the final bit so s never shows partial sums.
                    if (w_last) begin
                        r_s    <= {w_sum, r_sum_sh[WIDTH-1:1]};
                        r_cout <= w_carry ^ r_m;
                        r_ovf  <= r_carry ^ w_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign s           = r_s;
    assign cout        = r_cout;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: WIDTH=2, 8 and 32 instances, directed protocol steps and a random sweep
// checked against an integer-arithmetic reference model.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    logic        st2, st8, st32;

    logic        busy2, done2, cout2, ovf2;
    logic        busy8, done8, cout8, ovf8;
    logic        busy32, done32, cout32, ovf32;
    logic [1:0]  s2;
    logic [7:0]  s8;
    logic [31:0] s32;
    logic [1:0]  dbg2, dbg8, dbg32;

    int          sel = 8;
    logic [63:0] obs_s;
    logic        obs_busy, obs_done, obs_cout, obs_ovf;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(st2), .a(a[1:0]), .b(b[1:0]), .m(m),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2), .o_dbg_state(dbg2)
    );
    addsub_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a[7:0]), .b(b[7:0]), .m(m),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8), .o_dbg_state(dbg8)
    );
    addsub_serial #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(st32), .a(a), .b(b), .m(m),
        .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32), .o_dbg_state(dbg32)
    );

    always_comb begin
        obs_s    = {56'd0, s8};
        obs_busy = busy8;
        obs_done = done8;
        obs_cout = cout8;
        obs_ovf  = ovf8;
        case (sel)
            2: begin
                obs_s = {62'd0, s2}; obs_busy = busy2; obs_done = done2;
                obs_cout = cout2; obs_ovf = ovf2;
            end
            32: begin
                obs_s = {32'd0, s32}; obs_busy = busy32; obs_done = done32;
                obs_cout = cout32; obs_ovf = ovf32;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        case (sel)
            2:       st2  = v;
            32:      st32 = v;
            default: st8  = v;
        endcase
    endtask

    // Reference: plain unsigned/signed integer arithmetic at width w.
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic mv, output logic [63:0] es, output logic ec,
                                  output logic eo);
        longint unsigned mask, ua, ub;
        longint sa, sb, sr, half;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, av} & mask;
        ub   = {32'd0, bv} & mask;
        half = longint'(1) << (w - 1);
        sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
        if (!mv) begin
            es = (ua + ub) & mask;
            ec = ((ua + ub) >> w) != 0;
            sr = sa + sb;
        end else begin
            es = (ua - ub) & mask;
            ec = ua < ub;
            sr = sa - sb;
        end
        eo = (sr >= half) || (sr < -half);
    endfunction

    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic mv, input string tag);
        int          edges;
        int          busy_cnt;
        logic [63:0] es;
        logic        ec, eo;
        sel = w;
        a = av; b = bv; m = mv;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        a = $urandom; b = $urandom; m = 1'($urandom);
        edges    = 1;
        busy_cnt = 0;
        while (!obs_done && edges < w + 6) begin
            if (obs_busy) busy_cnt++;
            tick();
            edges++;
        end
        model(w, av, bv, mv, es, ec, eo);
        chk({tag, "_latency"}, 64'(edges), 64'(w + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(w));
        chk({tag, "_s"}, obs_s, es);
        chk({tag, "_cout"}, {63'd0, obs_cout}, {63'd0, ec});
        chk({tag, "_ovf"}, {63'd0, obs_ovf}, {63'd0, eo});
        tick();
        chk({tag, "_done_one_cycle"}, {63'd0, obs_done}, 64'd0);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] one;
        one = 32'd1;
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return one << (w - 1);
            3:       return (one << (w - 1)) - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        int last;
        int ws[3];

        rst = 1'b1; st2 = 1'b0; st8 = 1'b0; st32 = 1'b0;
        a = '0; b = '0; m = 1'b0;
        tick();
        tick();
        ws[0] = 2; ws[1] = 8; ws[2] = 32;
        foreach (ws[k]) begin
            sel = ws[k];
            #1;
            chk("reset_busy", {63'd0, obs_busy}, 64'd0);
            chk("reset_done", {63'd0, obs_done}, 64'd0);
            chk("reset_s", obs_s, 64'd0);
            chk("reset_cout", {63'd0, obs_cout}, 64'd0);
            chk("reset_ovf", {63'd0, obs_ovf}, 64'd0);
        end
        rst = 1'b0;
        sel = 8;
        tick();

        run_op(8, 32'd100, 32'd27, 1'b0, "add_100_27");
        run_op(8, 32'd100, 32'd28, 1'b0, "add_signed_ovf");
        run_op(8, 32'hFF, 32'h01, 1'b0, "add_wrap");
        run_op(8, 32'd5, 32'd7, 1'b1, "sub_borrow");
        run_op(8, 32'h80, 32'h01, 1'b1, "sub_signed_ovf");

        // Stray start pulses and operand churn during RUN must not disturb the result.
        sel = 8;
        a = 32'd20; b = 32'd30; m = 1'b0;
        st8 = 1'b1;
        tick();
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 1 && i <= 3) begin
                st8 = 1'b1;
                a = $urandom; b = $urandom; m = 1'($urandom);
            end else begin
                st8 = 1'b0;
            end
            tick();
            if (obs_done) begin
                dones++;
                chk("midrun_s", obs_s, 64'd50);
                chk("midrun_cout", {63'd0, obs_cout}, 64'd0);
                chk("midrun_ovf", {63'd0, obs_ovf}, 64'd0);
            end
        end
        chk("midrun_done_count", 64'(dones), 64'd1);

        // Start held high: one result every WIDTH+2 cycles.
        a = 32'd200; b = 32'd100; m = 1'b1;
        st8 = 1'b1;
        dones = 0;
        last = -1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            tick();
            if (obs_done) begin
                if (last >= 0) chk("b2b_period", 64'(cyc - last), 64'd10);
                chk("b2b_s", obs_s, 64'd100);
                last = cyc;
                dones++;
            end
        end
        chk("b2b_done_count", 64'(dones), 64'd4);
        st8 = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Reset on the 4th RUN cycle abandons the operation.
        a = 32'd77; b = 32'd11; m = 1'b0;
        st8 = 1'b1;
        tick();
        st8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", {63'd0, obs_busy}, 64'd0);
        chk("rst_mid_done", {63'd0, obs_done}, 64'd0);
        chk("rst_mid_s", obs_s, 64'd0);
        chk("rst_mid_cout", {63'd0, obs_cout}, 64'd0);
        chk("rst_mid_ovf", {63'd0, obs_ovf}, 64'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (obs_done) dones++;
        end
        chk("rst_no_done", 64'(dones), 64'd0);
        run_op(8, 32'd77, 32'd11, 1'b0, "after_rst");

        foreach (ws[k]) begin
            for (int n = 0; n < 350; n++) begin
                run_op(ws[k], pick(ws[k]), pick(ws[k]), 1'($urandom), $sformatf("rand_w%0d", ws[k]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
